// File: rtl/acp_pkg.sv
// Shared definitions for the ACP tone path: sequencer state encoding and note entry layout.
package acp_pkg;

  localparam int NOTE_PERIOD_W = 16;
  localparam int NOTE_DUR_W    = 12;
  localparam int NOTE_ADDR_W   = 3;

  // Note entry is {period, duration}: duration in the low bits, period directly above it.
  localparam int DUR_LSB = 0;

  function automatic int period_lsb(input int dur_w);
    return DUR_LSB + dur_w;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/tone_divider.sv
// Period counter for one voice: reloads period-1 and emits a registered step strobe at zero.
module tone_divider
  import acp_pkg::*;
#(
  parameter int PERIOD_W = NOTE_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_period,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic                keep,
  output logic                tone_tick
);

  logic [PERIOD_W-1:0] cnt_reg, cnt_next;
  logic                tick_reg, tick_next;

  // The strobe is registered from the next count so it lines up with the cycle the count sits at 0.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      if (load_period != '0) cnt_next = load_period - PERIOD_W'(1);
      else                   cnt_next = '0;
    end else if (run) begin
      if (cnt_reg != '0)      cnt_next = cnt_reg - PERIOD_W'(1);
      else if (period != '0)  cnt_next = period - PERIOD_W'(1);
    end
    tick_next = keep && (cnt_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      tick_reg <= tick_next;
    end
  end

  assign tone_tick = tick_reg;

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: steps through an 8-entry {period, duration} table and drives one square_gen voice.
module note_sequencer
  import acp_pkg::*;
#(
  parameter int PERIOD_W  = NOTE_PERIOD_W,
  parameter int DUR_W     = NOTE_DUR_W,
  parameter int ADDR_W    = NOTE_ADDR_W,
  parameter int TEMPO_DIV = 1000,
  parameter int GAP_CYC   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [PERIOD_W+DUR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]         last_idx,
  input  logic                      loop,
  input  logic                      start,
  input  logic                      stop,
  output logic                      tone_tick,
  output logic                      tone_en,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         cur_note
);

  localparam int ENTRY_W    = PERIOD_W + DUR_W;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int PRE_W      = $clog2(TEMPO_DIV);
  localparam int GAP_W      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LD     = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int PERIOD_LSB = period_lsb(DUR_W);

  logic [ENTRY_W-1:0]  table_reg [DEPTH];
  logic [ENTRY_W-1:0]  rd_entry;
  logic [PERIOD_W-1:0] rd_period;
  logic [DUR_W-1:0]    rd_dur;

  seq_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]   cur_note_reg, cur_note_next;
  logic [ADDR_W-1:0]   last_reg, last_next;
  logic                loop_reg, loop_next;
  logic [PERIOD_W-1:0] period_reg, period_next;
  logic [DUR_W-1:0]    dur_reg, dur_next;
  logic [PRE_W-1:0]    presc_reg, presc_next;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic                advance;
  logic                tone_en_reg, tone_en_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  // Table is register-based so that reset can clear every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) table_reg[i] <= '0;
    end else if (wr_en) begin
      table_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_entry  = table_reg[cur_note_reg];
  assign rd_period = rd_entry[PERIOD_LSB +: PERIOD_W];
  assign rd_dur    = rd_entry[DUR_LSB +: DUR_W];

  always_comb begin
    state_next    = state_reg;
    cur_note_next = cur_note_reg;
    last_next     = last_reg;
    loop_next     = loop_reg;
    period_next   = period_reg;
    dur_next      = dur_reg;
    presc_next    = presc_reg;
    gap_next      = gap_reg;
    advance       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (start && !stop) begin
          state_next    = ST_LOAD;
          cur_note_next = '0;
          last_next     = last_idx;
          loop_next     = loop;
        end
      end
      ST_LOAD: begin
        period_next = rd_period;
        dur_next    = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
        presc_next  = '0;
        state_next  = ST_PLAY;
      end
      ST_PLAY: begin
        if (presc_reg == PRE_W'(TEMPO_DIV - 1)) begin
          presc_next = '0;
          if (dur_reg == DUR_W'(1)) begin
            if (GAP_CYC > 0) begin
              state_next = ST_GAP;
              gap_next   = GAP_W'(GAP_LD);
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_next = dur_reg - DUR_W'(1);
          end
        end else begin
          presc_next = presc_reg + PRE_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_reg == '0) advance = 1'b1;
        else               gap_next = gap_reg - GAP_W'(1);
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (advance) begin
      if (cur_note_reg != last_reg) begin
        cur_note_next = cur_note_reg + ADDR_W'(1);
        state_next    = ST_LOAD;
      end else if (loop_reg) begin
        cur_note_next = '0;
        state_next    = ST_LOAD;
      end else begin
        state_next = ST_DONE;
      end
    end

    // Abort wins over every other transition, including a note end in the same cycle.
    if (stop && state_reg != ST_IDLE) state_next = ST_IDLE;

    tone_en_next = (state_next == ST_PLAY) && (period_next != '0);
    busy_next    = (state_next != ST_IDLE);
    done_next    = (state_next == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cur_note_reg <= '0;
      last_reg     <= '0;
      loop_reg     <= 1'b0;
      period_reg   <= '0;
      dur_reg      <= '0;
      presc_reg    <= '0;
      gap_reg      <= '0;
      tone_en_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_note_reg <= cur_note_next;
      last_reg     <= last_next;
      loop_reg     <= loop_next;
      period_reg   <= period_next;
      dur_reg      <= dur_next;
      presc_reg    <= presc_next;
      gap_reg      <= gap_next;
      tone_en_reg  <= tone_en_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  tone_divider #(
    .PERIOD_W (PERIOD_W)
  ) u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (state_reg == ST_LOAD),
    .load_period (rd_period),
    .run         (state_reg == ST_PLAY),
    .period      (period_reg),
    .keep        (tone_en_next),
    .tone_tick   (tone_tick)
  );

  assign tone_en  = tone_en_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign cur_note = cur_note_reg;

endmodule
